// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter: requester ids,
// in-flight tag layout and sizing constants.
package mem_arb_pkg;

  localparam int unsigned MaxOutstanding = 4;
  localparam int unsigned PtrW           = 2;
  localparam int unsigned CntW           = 3;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e id;
    logic    drop;
  } tag_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each in-flight memory
// request; flush_mark poisons every queued fetch tag.
module arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  req_id_e         push_id,
  input  logic            pop,
  input  logic            flush_mark,
  output tag_t            head,
  output logic [CntW-1:0] count
);

  tag_t            mem_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // Stale slots may get marked too; a push always rewrites drop to 0.
      if (flush_mark) begin
        for (int i = 0; i < int'(MaxOutstanding); i++) begin
          if (mem_q[i].id == REQ_IF) mem_q[i].drop <= 1'b1;
        end
      end
      if (push) begin
        mem_q[wptr_q] <= '{id: push_id, drop: 1'b0};
        wptr_q        <= next_ptr(wptr_q);
      end
      if (pop) rptr_q <= next_ptr(rptr_q);
      if (push && !pop) count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load-store, with grant lock under backpressure and in-order response routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_wdata,
  input  logic [3:0]  ls_req_wstrb,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        flush_if,
  output logic [2:0]  outstanding,
  output logic        rsp_err
);

  req_id_e         prio_q, gnt;
  logic            hold_q, hold_we_q, err_q;
  req_id_e         hold_id_q;
  logic [31:0]     hold_addr_q, hold_wdata_q;
  logic [3:0]      hold_wstrb_q;
  logic            full, xfer, stall, pop;
  tag_t            head;
  logic [CntW-1:0] cnt;

  always_comb begin
    gnt = REQ_IF;
    if (hold_q) gnt = hold_id_q;
    else if (if_req_valid && ls_req_valid) gnt = prio_q;
    else if (ls_req_valid) gnt = REQ_LS;
  end

  always_comb begin
    mem_addr  = if_req_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (hold_q) begin
      mem_addr  = hold_addr_q;
      mem_we    = hold_we_q;
      mem_wdata = hold_wdata_q;
      mem_wstrb = hold_wstrb_q;
    end else if (gnt == REQ_LS) begin
      mem_addr  = ls_req_addr;
      mem_we    = ls_req_we;
      mem_wdata = ls_req_wdata;
      mem_wstrb = ls_req_wstrb;
    end
  end

  // A pop in the same cycle deliberately does not relieve full.
  assign full          = (cnt == CntW'(OUTSTANDING));
  assign mem_req_valid = rst_n && (if_req_valid || ls_req_valid || hold_q) && !full;
  assign xfer          = mem_req_valid && mem_req_ready;
  assign stall         = mem_req_valid && !mem_req_ready;
  assign if_req_ready  = rst_n && (gnt == REQ_IF) && mem_req_ready && !full;
  assign ls_req_ready  = rst_n && (gnt == REQ_LS) && mem_req_ready && !full;

  assign pop          = mem_rsp_valid && (cnt != '0);
  assign if_rsp_valid = pop && (head.id == REQ_IF) && !head.drop && !flush_if;
  assign ls_rsp_valid = pop && (head.id == REQ_LS);
  assign if_rsp_rdata = mem_rsp_rdata;
  assign ls_rsp_rdata = mem_rsp_rdata;
  assign outstanding  = cnt;
  assign rsp_err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= REQ_IF;
      hold_q       <= 1'b0;
      hold_id_q    <= REQ_IF;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_wdata_q <= '0;
      hold_wstrb_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (xfer) begin
        hold_q <= 1'b0;
        prio_q <= (gnt == REQ_IF) ? REQ_LS : REQ_IF;
      end else if (stall) begin
        hold_q       <= 1'b1;
        hold_id_q    <= gnt;
        hold_addr_q  <= mem_addr;
        hold_we_q    <= mem_we;
        hold_wdata_q <= mem_wdata;
        hold_wstrb_q <= mem_wstrb;
      end
      if (mem_rsp_valid && (cnt == '0)) err_q <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .Depth (OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (xfer),
    .push_id    (gnt),
    .pop        (pop),
    .flush_mark (flush_if),
    .head       (head),
    .count      (cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// a queue-based reference model compared on every falling clock edge.
module tb_mem_port_arbiter;

  localparam int unsigned Out = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        ls_req_valid, ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [31:0] ls_req_wdata;
  logic [3:0]  ls_req_wstrb;
  logic        if_rsp_valid, ls_rsp_valid;
  logic [31:0] if_rsp_rdata, ls_rsp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        flush_if;
  logic [2:0]  outstanding;
  logic        rsp_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_port_arbiter #(
    .OUTSTANDING (Out)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_we     (ls_req_we),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wstrb  (ls_req_wstrb),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_rdata  (if_rsp_rdata),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_rdata  (ls_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .flush_if      (flush_if),
    .outstanding   (outstanding),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Reference model: queue of in-flight owners (0=IF, 1=LS) with drop flags,
  // preferred requester, and the request locked in by a stall.
  bit          q_id[$];
  bit          q_drop[$];
  bit          m_pref, m_lock, m_lock_id, m_lock_we, m_err;
  logic [31:0] m_lock_addr;
  bit          e_full, e_mv, e_g, e_pop, e_if, e_ls, e_we;
  logic [31:0] e_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_id.delete();
      q_drop.delete();
      m_pref = 1'b0;
      m_lock = 1'b0;
      m_err  = 1'b0;
      chkb("rst_mem_req_valid", mem_req_valid, 1'b0);
      chkb("rst_if_req_ready", if_req_ready, 1'b0);
      chkb("rst_ls_req_ready", ls_req_ready, 1'b0);
      chkb("rst_if_rsp_valid", if_rsp_valid, 1'b0);
      chkb("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chkb("rst_rsp_err", rsp_err, 1'b0);
    end else begin
      e_full = (q_id.size() == int'(Out));
      e_mv   = (if_req_valid || ls_req_valid || m_lock) && !e_full;
      if (m_lock) e_g = m_lock_id;
      else if (if_req_valid && ls_req_valid) e_g = m_pref;
      else e_g = ls_req_valid;
      e_addr = m_lock ? m_lock_addr : (e_g ? ls_req_addr : if_req_addr);
      e_we   = m_lock ? m_lock_we : (e_g ? ls_req_we : 1'b0);

      chkb("m_mem_req_valid", mem_req_valid, e_mv);
      if (e_mv) begin
        chk("m_mem_addr", mem_addr, e_addr);
        chkb("m_mem_we", mem_we, e_we);
      end
      if (if_req_valid) chkb("m_if_req_ready", if_req_ready, !e_g && mem_req_ready && !e_full);
      if (ls_req_valid) chkb("m_ls_req_ready", ls_req_ready, e_g && mem_req_ready && !e_full);

      e_pop = mem_rsp_valid && (q_id.size() > 0);
      e_if  = 1'b0;
      e_ls  = 1'b0;
      if (e_pop) begin
        e_if = !q_id[0] && !q_drop[0] && !flush_if;
        e_ls = q_id[0];
      end
      chkb("m_if_rsp_valid", if_rsp_valid, e_if);
      chkb("m_ls_rsp_valid", ls_rsp_valid, e_ls);
      if (e_if) chk("m_if_rsp_rdata", if_rsp_rdata, mem_rsp_rdata);
      if (e_ls) chk("m_ls_rsp_rdata", ls_rsp_rdata, mem_rsp_rdata);
      chk("m_outstanding", 32'(outstanding), 32'(q_id.size()));
      chkb("m_rsp_err", rsp_err, m_err);

      if (mem_rsp_valid && (q_id.size() == 0)) m_err = 1'b1;
      if (e_pop) begin
        void'(q_id.pop_front());
        void'(q_drop.pop_front());
      end
      if (flush_if) begin
        foreach (q_id[i]) if (!q_id[i]) q_drop[i] = 1'b1;
      end
      if (e_mv && mem_req_ready) begin
        q_id.push_back(e_g);
        q_drop.push_back(1'b0);
        m_pref = !e_g;
        m_lock = 1'b0;
      end else if (e_mv) begin
        m_lock      = 1'b1;
        m_lock_id   = e_g;
        m_lock_addr = e_addr;
        m_lock_we   = e_we;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    ls_req_valid  = 1'b0;
    ls_req_addr   = '0;
    ls_req_we     = 1'b0;
    ls_req_wdata  = '0;
    ls_req_wstrb  = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    flush_if      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n         = 1'b0;
    if_req_valid  = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chkb("reset_mem_req_valid", mem_req_valid, 1'b0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Both requesters always valid, memory answers one cycle later.
    for (int n = 0; n < 5; n++) begin
      if_req_valid  = (n < 4);
      ls_req_valid  = (n < 4);
      if_req_addr   = 32'h1000 + 32'(n * 4);
      ls_req_addr   = 32'h2000 + 32'(n * 4);
      mem_req_ready = 1'b1;
      mem_rsp_valid = (n > 0);
      mem_rsp_rdata = (n > 0) ? 32'h1111_0000 + 32'(n - 1) : '0;
      @(negedge clk);
      if (n < 4) begin
        chkb("rr_if_grant", if_req_ready, (n % 2) == 0);
        chkb("rr_ls_grant", ls_req_ready, (n % 2) == 1);
      end
      if (n > 0 && (n % 2) == 1) begin
        chkb("rr_if_rsp", if_rsp_valid, 1'b1);
        chk("rr_if_rdata", if_rsp_rdata, 32'h1111_0000 + 32'(n - 1));
      end
      if (n > 0 && (n % 2) == 0) begin
        chkb("rr_ls_rsp", ls_rsp_valid, 1'b1);
        chk("rr_ls_rdata", ls_rsp_rdata, 32'h1111_0000 + 32'(n - 1));
      end
      tick();
    end
    idle();
    tick();

    // Stalled LS write keeps the grant while IF shows up.
    for (int n = 0; n < 5; n++) begin
      ls_req_valid  = (n < 4);
      ls_req_addr   = 32'h8000_0040;
      ls_req_we     = 1'b1;
      ls_req_wdata  = 32'hDEAD_BEEF;
      ls_req_wstrb  = 4'hF;
      if_req_valid  = (n >= 1 && n < 4);
      if_req_addr   = 32'h0000_0100;
      mem_req_ready = (n == 3);
      mem_rsp_valid = (n == 4);
      mem_rsp_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      if (n < 4) begin
        chk("lock_mem_addr", mem_addr, 32'h8000_0040);
        chkb("lock_ls_ready", ls_req_ready, n == 3);
        chkb("lock_if_ready", if_req_ready, 1'b0);
      end else begin
        chkb("write_ls_rsp", ls_rsp_valid, 1'b1);
      end
      tick();
    end
    idle();
    tick();

    // Fill both slots; one response frees a slot only from the next cycle.
    for (int n = 0; n < 6; n++) begin
      if_req_valid  = (n < 4);
      if_req_addr   = 32'h200 + 32'(n * 4);
      mem_req_ready = 1'b1;
      mem_rsp_valid = (n == 2 || n == 4 || n == 5);
      mem_rsp_rdata = 32'hC0DE_0000 + 32'(n);
      @(negedge clk);
      if (n == 2) begin
        chkb("full_if_ready", if_req_ready, 1'b0);
        chkb("full_mem_valid", mem_req_valid, 1'b0);
        chk("full_outstanding", 32'(outstanding), 32'd2);
      end
      if (n == 3) begin
        chkb("freed_if_ready", if_req_ready, 1'b1);
        chk("freed_outstanding", 32'(outstanding), 32'd1);
      end
      if (n == 5) chkb("drain_if_rsp", if_rsp_valid, 1'b1);
      tick();
    end
    idle();
    tick();

    // Flush with two fetches in flight; next fetch accepted once a slot frees.
    for (int n = 0; n < 5; n++) begin
      if_req_valid  = (n < 4 && n != 2) || (n == 2);
      if_req_valid  = (n < 4);
      if_req_addr   = 32'h300 + 32'(n * 4);
      mem_req_ready = 1'b1;
      flush_if      = (n == 2);
      mem_rsp_valid = (n >= 2);
      mem_rsp_rdata = 32'hF100_0000 + 32'(n);
      if (n == 3) if_req_valid = 1'b1;
      if (n == 2) if_req_valid = 1'b1;
      if (n >= 4) if_req_valid = 1'b0;
      @(negedge clk);
      if (n == 2) chkb("flush_rsp1", if_rsp_valid, 1'b0);
      if (n == 3) chkb("flush_rsp2", if_rsp_valid, 1'b0);
      if (n == 4) chkb("flush_rsp3", if_rsp_valid, 1'b1);
      tick();
      if (n == 3) if_req_valid = 1'b0;
    end
    idle();
    tick();

    // Fetch transferred in the flush cycle survives the flush.
    for (int n = 0; n < 4; n++) begin
      if_req_valid  = (n < 2);
      if_req_addr   = 32'h400 + 32'(n * 4);
      mem_req_ready = 1'b1;
      flush_if      = (n == 1);
      mem_rsp_valid = (n >= 2);
      mem_rsp_rdata = 32'hF200_0000 + 32'(n);
      @(negedge clk);
      if (n == 1) chkb("flush_same_cycle_ready", if_req_ready, 1'b1);
      if (n == 2) chkb("flush_old_dropped", if_rsp_valid, 1'b0);
      if (n == 3) chkb("flush_new_kept", if_rsp_valid, 1'b1);
      tick();
    end
    idle();
    tick();

    // Response with nothing outstanding is a sticky error.
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD0_0001;
    @(negedge clk);
    chkb("orphan_no_if_rsp", if_rsp_valid, 1'b0);
    chkb("orphan_no_ls_rsp", ls_rsp_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chkb("orphan_err_set", rsp_err, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chkb("orphan_err_sticky", rsp_err, 1'b1);
    tick();

    // LS then IF in flight (preference now LS), then reset mid-transaction.
    mem_req_ready = 1'b1;
    ls_req_valid  = 1'b1;
    ls_req_addr   = 32'h600;
    tick();
    ls_req_valid = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h500;
    tick();
    idle();
    @(negedge clk);
    chk("pre_reset_outstanding", 32'(outstanding), 32'd2);
    tick();
    rst_n         = 1'b0;
    if_req_valid  = 1'b1;
    ls_req_valid  = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    chk("async_reset_outstanding", 32'(outstanding), 32'd0);
    chkb("async_reset_err", rsp_err, 1'b0);
    chkb("async_reset_mem_valid", mem_req_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chkb("post_reset_if_first", if_req_ready, 1'b1);
    chkb("post_reset_ls_waits", ls_req_ready, 1'b0);
    tick();
    idle();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chkb("post_reset_orphan_err", rsp_err, 1'b1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: OUTSTANDING, default 2, max accepted-but-unanswered memory requests (range 1..4).
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 if_req_valid/if_req_ready  input/output  1/1  instruction-fetch request handshake.
REQ-005 if_req_addr  input  32  fetch word address; fetch is always a read.
REQ-006 ls_req_valid/ls_req_ready  input/output  1/1  load-store request handshake.
REQ-007 ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wstrb  input  32/1/32/4  load-store address, write enable, write data, byte strobes.
REQ-008 if_rsp_valid, if_rsp_rdata / ls_rsp_valid, ls_rsp_rdata  output  1/32 each  per-requester read response; no backpressure.
REQ-009 mem_req_valid/mem_req_ready  output/input  1/1  shared memory port handshake.
REQ-010 mem_addr, mem_we, mem_wdata, mem_wstrb  output  32/1/32/4  forwarded request fields of the granted requester.
REQ-011 mem_rsp_valid, mem_rsp_rdata  input  1/32  in-order memory response, one per accepted request (writes included).
REQ-012 flush_if  input  1  trap/redirect pulse; discards in-flight fetch responses.
REQ-013 outstanding  output  3  count of accepted, unanswered requests.
REQ-014 rsp_err  output  1  sticky protocol-error flag.

Function
REQ-015 Transfer occurs when mem_req_valid && mem_req_ready; the granted requester's req_ready equals mem_req_ready && !full; the other requester's req_ready is 0.
REQ-016 mem_req_valid = (if_req_valid || ls_req_valid || hold) && !full, where full = (outstanding == OUTSTANDING); a pop in the same cycle does not relieve full.
REQ-017 Arbitration is round-robin: priority pointer selects preferred requester when both valid; pointer moves to the non-granted requester after every transfer; reset value prefers fetch.
REQ-018 Grant lock: once mem_req_valid is high without mem_req_ready, grant and all mem_* fields hold until transfer; hold state lives in a register set on a stalled cycle and cleared on transfer.
REQ-019 Each transfer pushes {requester id, drop=0} into an in-order tag FIFO of depth OUTSTANDING; each mem_rsp_valid pops the head.
REQ-020 Response routing: pop with head id=IF raises if_rsp_valid for exactly that cycle unless head.drop or flush_if; id=LS raises ls_rsp_valid; rdata passes through combinationally (zero added latency).
REQ-021 Write responses (LS, we=1) still raise ls_rsp_valid; rdata is don't-care.
REQ-022 flush_if sets drop on all IF entries present before the edge; an IF request transferred in the flush cycle is kept (drop=0).
REQ-023 Simultaneous push and pop: outstanding unchanged, FIFO wrap-around of read/write pointers modulo OUTSTANDING.
REQ-024 mem_rsp_valid with outstanding == 0: response ignored, no output pulse, rsp_err set and held until reset.
REQ-025 Minimum request-to-response latency through the arbiter is 0 added cycles; throughput one transfer per cycle when not full.

Reset
REQ-026 On rst_n low: outstanding=0, FIFO pointers=0, hold=0, priority=fetch, rsp_err=0; all valid/ready outputs 0 while reset asserted.
REQ-027 Reset mid-transaction discards all tags; responses arriving after reset release with empty FIFO set rsp_err.

Structure
REQ-028 Shared package mem_arb_pkg holds the requester-id enum (REQ_IF, REQ_LS), tag struct {id, drop}, and max-OUTSTANDING constant.
REQ-029 Tag FIFO is one sub-module, arb_tag_fifo, with push, pop, flush-mark, count; arbitration and lock logic remain in the top.

Verification
REQ-030 Both valid every cycle, mem_req_ready=1, 1-cycle memory: grants alternate IF,LS,IF,LS; responses routed with matching rdata 0x1111_0000+n.
REQ-031 LS valid, mem_req_ready=0 for 3 cycles while IF becomes valid on cycle 2: LS stays granted, mem_addr stable at 0x8000_0040 until transfer.
REQ-032 OUTSTANDING=2, memory withholds responses: third request sees req_ready=0, outstanding=2; one response then frees the slot next cycle.
REQ-033 Two IF reads in flight, flush_if pulse, IF request same cycle: first two responses produce no if_rsp_valid, third produces if_rsp_valid.
REQ-034 mem_rsp_valid pulse with outstanding=0: no rsp pulse, rsp_err=1 until rst_n low.
REQ-035 rst_n low with two outstanding: outstanding=0, rsp_err=0, priority back to fetch on release.
